// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: speed encodings and default prescaler ratios
// for a 125 MHz system clock.
package eth_pkg;

   localparam logic [1:0] SPEED_10M   = 2'b00;
   localparam logic [1:0] SPEED_100M  = 2'b01;
   localparam logic [1:0] SPEED_1000M = 2'b10;

   localparam int DEF_DIV_100M = 5;
   localparam int DEF_DIV_10M  = 50;

   // 2'b11 is not a legal MII rate and is run as gigabit
   function automatic logic is_gig(input logic [1:0] spd);
      return (spd == SPEED_1000M) || (spd == 2'b11);
   endfunction

endpackage

// File: rtl/rate_ce_gen.sv
// Nibble-rate prescaler: one tick per nibble period in MII modes, a tick
// every cycle at gigabit.
module rate_ce_gen
   import eth_pkg::*;
#(
   parameter int DIV_100M = DEF_DIV_100M,
   parameter int DIV_10M  = DEF_DIV_10M,
   parameter int CNT_W    = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [1:0] div_sel,
   output logic       tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_last;

   always_comb begin
      cnt_last = (div_sel == SPEED_100M) ? CNT_W'(DIV_100M - 1) : CNT_W'(DIV_10M - 1);
      tick     = is_gig(div_sel) ? 1'b1 : (cnt == cnt_last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || is_gig(div_sel) || (cnt == cnt_last)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/gmii_mii_rate_adapter.sv
// Single-clock MAC/PHY adapter: GMII byte pass-through at 1000M, MII nibble
// packing/unpacking at 100M/10M using clock-enable strobes.
module gmii_mii_rate_adapter
   import eth_pkg::*;
#(
   parameter int DIV_100M   = DEF_DIV_100M,
   parameter int DIV_10M    = DEF_DIV_10M,
   parameter int RST_STAGES = 4,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] speed,
   output logic       mac_rst,
   output logic       mac_clk_en,
   input  logic [7:0] mac_txd,
   input  logic       mac_tx_en,
   input  logic       mac_tx_er,
   output logic       mac_rx_ce,
   output logic [7:0] mac_rxd,
   output logic       mac_rx_dv,
   output logic       mac_rx_er,
   output logic       phy_tx_ce,
   output logic [7:0] phy_txd,
   output logic       phy_tx_en,
   output logic       phy_tx_er,
   input  logic       phy_rx_ce,
   input  logic [7:0] phy_rxd,
   input  logic       phy_rx_dv,
   input  logic       phy_rx_er,
   output logic       rx_odd_nibble
);

   localparam int RST_W = $clog2(RST_STAGES + 1);

   logic [1:0]       speed_q;
   logic [RST_W-1:0] rst_cnt;
   logic             speed_chg;
   logic             hold;
   logic             gig;
   logic             tick;
   logic             tx_phase;
   logic [3:0]       tx_hi;
   logic             rx_phase;
   logic [3:0]       rx_low;
   logic             rx_er_low;

   // hold covers the stretch and the cycle a speed change is first seen
   always_comb begin
      speed_chg  = (speed != speed_q);
      hold       = mac_rst | speed_chg;
      gig        = is_gig(speed_q);
      phy_tx_ce  = !hold && tick;
      mac_clk_en = !hold && tick && (gig || !tx_phase);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed_q <= SPEED_1000M;
         rst_cnt <= RST_W'(RST_STAGES);
         mac_rst <= 1'b1;
      end else begin
         speed_q <= speed;
         mac_rst <= speed_chg || (rst_cnt != '0);
         if (speed_chg) begin
            rst_cnt <= RST_W'(RST_STAGES - 1);
         end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
         end
      end
   end

   rate_ce_gen #(
      .DIV_100M (DIV_100M),
      .DIV_10M  (DIV_10M),
      .CNT_W    (CNT_W)
   ) u_rate_ce_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (hold),
      .div_sel (speed_q),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phy_txd   <= '0;
         phy_tx_en <= 1'b0;
         phy_tx_er <= 1'b0;
         tx_phase  <= 1'b0;
         tx_hi     <= '0;
      end else if (hold) begin
         phy_txd   <= '0;
         phy_tx_en <= 1'b0;
         phy_tx_er <= 1'b0;
         tx_phase  <= 1'b0;
         tx_hi     <= '0;
      end else if (gig) begin
         phy_txd   <= mac_txd;
         phy_tx_en <= mac_tx_en;
         phy_tx_er <= mac_tx_er;
         tx_phase  <= 1'b0;
      end else if (tick) begin
         // en/er are latched with the low nibble and ride along with the high one
         if (!tx_phase) begin
            phy_txd   <= {4'h0, mac_txd[3:0]};
            phy_tx_en <= mac_tx_en;
            phy_tx_er <= mac_tx_er;
            tx_hi     <= mac_txd[7:4];
         end else begin
            phy_txd <= {4'h0, tx_hi};
         end
         tx_phase <= !tx_phase;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_rx_ce     <= 1'b0;
         mac_rxd       <= '0;
         mac_rx_dv     <= 1'b0;
         mac_rx_er     <= 1'b0;
         rx_phase      <= 1'b0;
         rx_low        <= '0;
         rx_er_low     <= 1'b0;
         rx_odd_nibble <= 1'b0;
      end else if (hold) begin
         mac_rx_ce     <= 1'b0;
         mac_rxd       <= '0;
         mac_rx_dv     <= 1'b0;
         mac_rx_er     <= 1'b0;
         rx_phase      <= 1'b0;
         rx_low        <= '0;
         rx_er_low     <= 1'b0;
         rx_odd_nibble <= 1'b0;
      end else begin
         mac_rx_ce <= 1'b0;
         if (phy_rx_ce) begin
            if (gig) begin
               mac_rxd   <= phy_rxd;
               mac_rx_dv <= phy_rx_dv;
               mac_rx_er <= phy_rx_er;
               mac_rx_ce <= 1'b1;
            end else if (!phy_rx_dv) begin
               // a dangling low nibble is flushed as an errored byte
               rx_phase <= 1'b0;
               if (rx_phase) begin
                  mac_rxd       <= {4'h0, rx_low};
                  mac_rx_dv     <= 1'b1;
                  mac_rx_er     <= 1'b1;
                  mac_rx_ce     <= 1'b1;
                  rx_odd_nibble <= 1'b1;
               end
            end else if (!rx_phase) begin
               rx_low    <= phy_rxd[3:0];
               rx_er_low <= phy_rx_er;
               rx_phase  <= 1'b1;
            end else begin
               mac_rxd   <= {phy_rxd[3:0], rx_low};
               mac_rx_dv <= 1'b1;
               mac_rx_er <= rx_er_low | phy_rx_er;
               mac_rx_ce <= 1'b1;
               rx_phase  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_gmii_mii_rate_adapter.sv
// Directed self-checking bench for gmii_mii_rate_adapter.
module tb_gmii_mii_rate_adapter;

   logic       clk;
   logic       rst_n;
   logic [1:0] speed;
   logic       mac_rst;
   logic       mac_clk_en;
   logic [7:0] mac_txd;
   logic       mac_tx_en;
   logic       mac_tx_er;
   logic       mac_rx_ce;
   logic [7:0] mac_rxd;
   logic       mac_rx_dv;
   logic       mac_rx_er;
   logic       phy_tx_ce;
   logic [7:0] phy_txd;
   logic       phy_tx_en;
   logic       phy_tx_er;
   logic       phy_rx_ce;
   logic [7:0] phy_rxd;
   logic       phy_rx_dv;
   logic       phy_rx_er;
   logic       rx_odd_nibble;

   int n_checks = 0;
   int n_errors = 0;

   gmii_mii_rate_adapter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .speed         (speed),
      .mac_rst       (mac_rst),
      .mac_clk_en    (mac_clk_en),
      .mac_txd       (mac_txd),
      .mac_tx_en     (mac_tx_en),
      .mac_tx_er     (mac_tx_er),
      .mac_rx_ce     (mac_rx_ce),
      .mac_rxd       (mac_rxd),
      .mac_rx_dv     (mac_rx_dv),
      .mac_rx_er     (mac_rx_er),
      .phy_tx_ce     (phy_tx_ce),
      .phy_txd       (phy_txd),
      .phy_tx_en     (phy_tx_en),
      .phy_tx_er     (phy_tx_er),
      .phy_rx_ce     (phy_rx_ce),
      .phy_rxd       (phy_rxd),
      .phy_rx_dv     (phy_rx_dv),
      .phy_rx_er     (phy_rx_er),
      .rx_odd_nibble (rx_odd_nibble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // counts mac_rst-high samples until release; flags any strobe/data leaking out
   task automatic wait_stretch(input string tag, input int n0);
      int n = n0;
      int i = 0;
      logic bad = 1'b0;
      do begin
         @(negedge clk);
         if (mac_rst) begin
            n++;
            if (mac_clk_en || phy_tx_ce || mac_rx_ce || phy_tx_en || phy_tx_er ||
                mac_rx_dv || mac_rx_er || rx_odd_nibble || (phy_txd != 8'h00) ||
                (mac_rxd != 8'h00))
               bad = 1'b1;
         end
         i++;
      end while ((mac_rst || n == 0) && i < 20);
      chk({tag, "_len"}, n, 4);
      chk({tag, "_quiet"}, {31'd0, bad}, 0);
   endtask

   task automatic rx_nib(input logic [3:0] nib, input logic dv, input logic er);
      @(negedge clk);
      phy_rxd   = {4'h0, nib};
      phy_rx_dv = dv;
      phy_rx_er = er;
      phy_rx_ce = 1'b1;
      @(negedge clk);
      phy_rx_ce = 1'b0;
      phy_rx_dv = 1'b0;
      phy_rx_er = 1'b0;
   endtask

   // TX cadence monitor: checks strobe periods, returns the first four words
   task automatic tx_periods(input string tag, input int cycles, input int ce_per,
                             input int en_per, output logic [7:0] w0, output logic [7:0] w1,
                             output logic [7:0] w2, output logic [7:0] w3);
      logic [7:0] words[$];
      int   ce_prev = -1;
      int   en_prev = -1;
      int   nbytes  = 0;
      logic prev_ce = 1'b0;
      logic pend    = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (pend) begin
            mac_txd   = (nbytes == 1) ? 8'hD5 : 8'h00;
            mac_tx_en = (nbytes == 1);
            pend      = 1'b0;
         end
         if (prev_ce) words.push_back(phy_txd);
         if (phy_tx_ce) begin
            if (ce_prev >= 0) chk({tag, "_ce_period"}, c - ce_prev, ce_per);
            ce_prev = c;
         end
         prev_ce = phy_tx_ce;
         if (mac_clk_en) begin
            if (en_prev >= 0) chk({tag, "_clken_period"}, c - en_prev, en_per);
            en_prev = c;
            nbytes++;
            pend = 1'b1;
         end
      end
      chk({tag, "_nwords"}, {31'd0, words.size() >= 4}, 1);
      w0 = (words.size() > 0) ? words[0] : 8'hxx;
      w1 = (words.size() > 1) ? words[1] : 8'hxx;
      w2 = (words.size() > 2) ? words[2] : 8'hxx;
      w3 = (words.size() > 3) ? words[3] : 8'hxx;
   endtask

   initial begin
      logic [7:0] w0, w1, w2, w3;
      rst_n     = 1'b0;
      speed     = 2'b10;
      mac_txd   = 8'h00;
      mac_tx_en = 1'b0;
      mac_tx_er = 1'b0;
      phy_rx_ce = 1'b0;
      phy_rxd   = 8'h00;
      phy_rx_dv = 1'b0;
      phy_rx_er = 1'b0;

      // reset and stretch
      repeat (3) @(negedge clk);
      chk("rst_mac_rst", {31'd0, mac_rst}, 1);
      chk("rst_outs", {mac_clk_en, mac_rx_ce, mac_rxd, mac_rx_dv, mac_rx_er, phy_tx_ce,
                       phy_txd, phy_tx_en, phy_tx_er, rx_odd_nibble}, 0);
      rst_n = 1'b1;
      wait_stretch("rst_stretch", 0);

      // 1000M pass-through
      mac_txd   = 8'hA5;
      mac_tx_en = 1'b1;
      @(negedge clk);
      chk("g_txd", {phy_tx_ce, mac_clk_en, phy_tx_en, phy_txd}, {3'b111, 8'hA5});
      mac_tx_en = 1'b0;
      mac_txd   = 8'h00;
      phy_rxd   = 8'h3C;
      phy_rx_dv = 1'b1;
      phy_rx_ce = 1'b1;
      @(negedge clk);
      phy_rx_ce = 1'b0;
      phy_rx_dv = 1'b0;
      chk("g_rx", {mac_rx_ce, mac_rx_dv, mac_rx_er, mac_rxd}, {3'b110, 8'h3C});
      @(negedge clk);
      chk("g_rx_hold", {mac_rx_ce, mac_rx_dv, mac_rxd}, {2'b01, 8'h3C});
      chk("g_tx_ce_const", {31'd0, phy_tx_ce}, 1);

      // switch to 100M, TX 5D then D5
      speed     = 2'b01;
      mac_txd   = 8'h5D;
      mac_tx_en = 1'b1;
      wait_stretch("s100_stretch", 0);
      tx_periods("tx100", 60, 5, 10, w0, w1, w2, w3);
      chk("tx100_w0", w0, 8'h0D);
      chk("tx100_w1", w1, 8'h05);
      chk("tx100_w2", w2, 8'h05);
      chk("tx100_w3", w3, 8'h0D);
      mac_txd   = 8'h00;
      mac_tx_en = 1'b0;

      // 100M RX: 5,5(er),D,5
      rx_nib(4'h5, 1'b1, 1'b0);
      chk("rx100_n1", {31'd0, mac_rx_ce}, 0);
      rx_nib(4'h5, 1'b1, 1'b1);
      chk("rx100_b0", {mac_rx_ce, mac_rx_dv, mac_rx_er, mac_rxd}, {3'b111, 8'h55});
      rx_nib(4'hD, 1'b1, 1'b0);
      chk("rx100_n3", {31'd0, mac_rx_ce}, 0);
      rx_nib(4'h5, 1'b1, 1'b0);
      chk("rx100_b1", {mac_rx_ce, mac_rx_dv, mac_rx_er, mac_rxd}, {3'b110, 8'h5D});
      rx_nib(4'h0, 1'b0, 1'b0);
      chk("rx100_idle", {mac_rx_ce, rx_odd_nibble}, 0);
      rx_nib(4'hF, 1'b0, 1'b1);
      chk("rx100_cext", {mac_rx_ce, rx_odd_nibble, mac_rxd}, {2'b00, 8'h5D});

      // odd frame 1,2,3
      rx_nib(4'h1, 1'b1, 1'b0);
      rx_nib(4'h2, 1'b1, 1'b0);
      chk("odd_b0", {mac_rx_ce, mac_rx_dv, mac_rx_er, mac_rxd}, {3'b110, 8'h21});
      rx_nib(4'h3, 1'b1, 1'b0);
      chk("odd_n3", {31'd0, mac_rx_ce}, 0);
      rx_nib(4'h0, 1'b0, 1'b0);
      chk("odd_b1", {mac_rx_ce, mac_rx_dv, mac_rx_er, mac_rxd}, {3'b111, 8'h03});
      chk("odd_flag", {31'd0, rx_odd_nibble}, 1);
      repeat (5) @(negedge clk);
      chk("odd_sticky", {mac_rx_ce, rx_odd_nibble}, 2'b01);

      // speed change 100M -> 10M mid-frame
      mac_txd   = 8'h77;
      mac_tx_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (phy_tx_en) break;
      end
      chk("s10_pre_en", {31'd0, phy_tx_en}, 1);
      speed = 2'b00;
      wait_stretch("s10_stretch", 0);
      chk("s10_odd_clr", {31'd0, rx_odd_nibble}, 0);
      mac_txd = 8'h5D;
      tx_periods("tx10", 260, 50, 100, w0, w1, w2, w3);
      chk("tx10_w0", w0, 8'h0D);
      chk("tx10_w1", w1, 8'h05);
      mac_txd   = 8'h00;
      mac_tx_en = 1'b0;

      // speed change coincident with phy_rx_ce: strobe dropped; 2'b11 runs as gigabit
      speed     = 2'b11;
      phy_rxd   = 8'h99;
      phy_rx_dv = 1'b1;
      phy_rx_ce = 1'b1;
      @(negedge clk);
      phy_rx_ce = 1'b0;
      phy_rx_dv = 1'b0;
      chk("sc_rx_drop", {mac_rst, mac_rx_ce, mac_rxd}, {2'b10, 8'h00});
      wait_stretch("s11_stretch", 1);
      chk("s11_gig", {phy_tx_ce, mac_clk_en}, 2'b11);
      @(negedge clk);
      chk("s11_gig2", {phy_tx_ce, mac_clk_en, mac_rx_ce}, 3'b110);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gmii_mii_rate_adapter.md
Name: gmii_mii_rate_adapter

Overview:
- Single-clock MAC/PHY adapter that replaces the fixed GMII pass-through with a speed-selectable path: 1000M GMII byte mode, or 100M/10M MII nibble mode.
- Everything runs on one 125 MHz clock, with clock-enable strobes instead of separate rx/tx clocks.
- Sits between the Ethernet MAC and the SDR/DDR I/O primitives; adds nibble↔byte conversion, rate prescaling and reset-on-speed-change.

Parameters:
DIV_100M, 5, clk cycles per nibble period at 100M
DIV_10M, 50, clk cycles per nibble period at 10M
RST_STAGES, 4, cycles mac_rst stays high after rst_n release or speed change (≥2)
CNT_W, 6, prescaler counter width; must hold DIV_10M-1

Ports:
clk  in  1  system clock, 125 MHz
rst_n  in  1  asynchronous reset, active-low
speed  in  2  2'b10=1000M, 2'b01=100M, 2'b00=10M, 2'b11 treated as 1000M
mac_rst  out  1  synchronous reset to MAC, active-high
mac_clk_en  out  1  TX byte-accept strobe to MAC
mac_txd  in  8  TX byte
mac_tx_en  in  1  TX enable
mac_tx_er  in  1  TX error
mac_rx_ce  out  1  one-cycle strobe: mac_rxd/dv/er valid
mac_rxd  out  8  RX byte
mac_rx_dv  out  1  RX data valid
mac_rx_er  out  1  RX error
phy_tx_ce  out  1  strobe marking each new phy_tx* word (drives output register/clock gen)
phy_txd  out  8  TX data; [7:4]=0 in MII mode
phy_tx_en  out  1  TX enable to PHY
phy_tx_er  out  1  TX error to PHY
phy_rx_ce  in  1  strobe: phy_rx* sampled valid this cycle (from oversampling front end)
phy_rxd  in  8  RX data; only [3:0] used in MII mode
phy_rx_dv  in  1  RX data valid
phy_rx_er  in  1  RX error
rx_odd_nibble  out  1  sticky: frame ended on odd nibble count; cleared by mac_rst

Behaviour:
- Reset (rst_n low, async): every output 0 except mac_rst=1; counters and phases 0; speed_q=2'b10.
- rst_n release: mac_rst held 1 for RST_STAGES clk cycles, then 0. mac_clk_en, phy_tx_ce and mac_rx_ce stay 0 while mac_rst=1.
- Speed change: speed registered into speed_q every cycle.
  - If speed != speed_q, the change restarts the RST_STAGES stretch.
  - Prescaler, TX phase and RX phase clear; phy_tx*/mac_rx* forced to 0 during the stretch.
  - A frame in flight is truncated, with no error flag.
- Prescaler (rate_ce_gen):
  - 1000M: tick=1 every cycle.
  - MII: cnt counts 0..DIV-1 and wraps; tick=1 when cnt==DIV-1.
- TX, 1000M:
  - mac_clk_en=1 and phy_tx_ce=1 every cycle.
  - phy_txd/en/er <= mac_txd/en/er; latency 1 cycle.
- TX, MII: phy_tx_ce=tick. tx_phase toggles on each tick.
  - Tick with tx_phase=0: mac_clk_en=1 the same cycle. Byte, en and er are captured; phy_txd <= {4'h0, mac_txd[3:0]}; phy_tx_en/er <= mac_tx_en/er.
  - Tick with tx_phase=1: phy_txd <= {4'h0, captured[7:4]}; en/er held from the capture.
  - mac_clk_en therefore pulses once per 2*DIV cycles.
- RX, 1000M:
  - On phy_rx_ce: mac_rxd/dv/er <= phy_rx*; mac_rx_ce pulses 1 cycle later (latency 1).
- RX, MII: acts on phy_rx_ce only.
  - phy_rx_dv=0: rx_phase <= 0.
  - If rx_phase was 1 at that point, emit the partial byte: {4'h0, low}, dv=1, er=1, mac_rx_ce pulse, rx_odd_nibble <= 1.
  - Otherwise, while dv=0, emit nothing. dv=0 nibbles carrying only er (carrier extension) are ignored.
  - dv=1 with rx_phase=0: store low nibble and er, rx_phase <= 1.
  - dv=1 with rx_phase=1: emit {phy_rxd[3:0], low}, dv=1, er=er_low|phy_rx_er; mac_rx_ce pulses the next cycle; rx_phase <= 0.
  - First nibble after dv rises is always the low nibble; no SFD realignment in this block.
- mac_rxd/dv/er hold their value between mac_rx_ce pulses.
- Simultaneous speed change and phy_rx_ce: speed change wins; the strobe is dropped.

Decomposition:
- Shared package eth_pkg:
  - speed constants SPEED_10M/100M/1000M, 2 bits;
  - default DIV_100M/DIV_10M localparams for 125 MHz.
- Sub-module rate_ce_gen (clk, rst_n, clr, div_sel → tick) holds the prescaler.
- Nibble packing and unpacking stay in the top module.

Test Plan:
- Reset/stretch: rst_n low 3 cycles then high → mac_rst=1 for exactly 4 cycles after release; all other outputs 0 throughout.
- 1000M TX/RX: mac_txd=8'hA5, en=1 → phy_txd=8'hA5 next cycle, phy_tx_ce constant 1; phy_rxd=8'h3C with ce → mac_rxd=8'h3C, mac_rx_ce 1 cycle later.
- 100M TX: bytes 8'h5D, 8'hD5 → mac_clk_en every 10 cycles; phy_txd sequence 0D,05,05,0D, each held 5 cycles; phy_tx_ce period 5.
- 100M RX: nibbles 5,5,D,5 with dv=1 → bytes 8'h55, 8'h5D, each with one mac_rx_ce pulse; er on the 2nd nibble only → that byte er=1.
- Odd frame: 3 nibbles (1,2,3) then dv=0 → bytes 8'h21 and 8'h03, the latter with er=1; rx_odd_nibble=1 until mac_rst.
- Speed change mid-frame: switch 100M→10M during TX → mac_rst high 4 cycles, phy_tx_en=0; afterwards phy_tx_ce period 50 and mac_clk_en period 100.
